// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM state type and default CAM geometry
package cam_pkg;
  typedef enum logic {IDLE, FLUSH} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/cam_entry.sv
// cam_entry: one stored word plus valid bit; ports clk/reset, we+wdata+wvalid write, clr invalidate, key+mask compare -> hit
module cam_entry
  import cam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             clr,
  input  logic             wvalid,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] mask,
  output logic             hit
);
  logic [WIDTH-1:0] data;
  logic             valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      data  <= wdata;
      valid <= wvalid;
    end
  end
  assign hit = valid && ((data ^ key) & mask) == '0;
endmodule

// File: rtl/cam_array.sv
// cam_array: masked-search CAM with 1-cycle registered lowest-index result and sequential flush; write/search/flush inputs, busy and result outputs
module cam_array
  import cam_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [WIDTH-1:0]  write_data_i,
  input  logic              write_valid_i,
  input  logic              search_enable_i,
  input  logic [WIDTH-1:0]  search_i,
  input  logic [WIDTH-1:0]  search_mask_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic              match_o,
  output logic [ADDR_W-1:0] match_addr_o,
  output logic [DEPTH-1:0]  match_vector_o
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, enc;
  logic [DEPTH-1:0]  hits;
  logic              search_ok;
  assign busy_o    = state == FLUSH;
  assign search_ok = search_enable_i && !busy_o;
  always_comb state_n = busy_o ? (ptr == ADDR_W'(DEPTH - 1) ? IDLE : FLUSH) : (flush_i ? FLUSH : IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= busy_o ? ptr + 1'b1 : '0;
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    cam_entry #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .reset (reset),
      .we    (write_enable_i && !busy_o && write_addr_i == ADDR_W'(k)),
      .clr   (busy_o && ptr == ADDR_W'(k)),
      .wvalid(write_valid_i),
      .wdata (write_data_i),
      .key   (search_i),
      .mask  (search_mask_i),
      .hit   (hits[k])
    );
  end
  always_comb begin
    enc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) enc = hits[i] ? ADDR_W'(i) : enc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid_o <= 1'b0;
      match_o        <= 1'b0;
      match_addr_o   <= '0;
      match_vector_o <= '0;
    end else begin
      result_valid_o <= search_ok;
      if (search_ok) begin
        match_o        <= |hits;
        match_addr_o   <= enc;
        match_vector_o <= hits;
      end
    end
  end
endmodule

// File: doc/cam_array.md
CAM_ARRAY -- requirements
Module: cam_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per stored word.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 2).
REQ-003 SHALL have derived parameter ADDR_W = $clog2(DEPTH), the entry index width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port write_enable_i, input, 1, write request this cycle.
REQ-007 SHALL have port write_addr_i, input, ADDR_W, target entry of the write.
REQ-008 SHALL have port write_data_i, input, WIDTH, word to store.
REQ-009 SHALL have port write_valid_i, input, 1, valid bit to store (0 = invalidate entry).
REQ-010 SHALL have port search_enable_i, input, 1, search request this cycle.
REQ-011 SHALL have port search_i, input, WIDTH, search key.
REQ-012 SHALL have port search_mask_i, input, WIDTH, per-bit compare enable (1 = compare, 0 = don't care).
REQ-013 SHALL have port flush_i, input, 1, start a sequential invalidate of all entries.
REQ-014 SHALL have port busy_o, output, 1, high while a flush is in progress.
REQ-015 SHALL have port result_valid_o, output, 1, search result is present this cycle.
REQ-016 SHALL have port match_o, output, 1, at least one entry matched.
REQ-017 SHALL have port match_addr_o, output, ADDR_W, lowest matching entry index.
REQ-018 SHALL have port match_vector_o, output, DEPTH, per-entry match bits.

Function
REQ-019 A write SHALL update data[write_addr_i] and valid[write_addr_i] on the edge that samples write_enable_i=1, provided busy_o=0.
REQ-020 Entry k SHALL match iff valid[k]=1 and ((data[k] ^ search_i) & search_mask_i) == 0.
REQ-021 A search SHALL have 1-cycle latency: a search sampled at edge N drives result_valid_o=1, match_vector_o, match_o and match_addr_o, all registered, during cycle N+1.
REQ-022 result_valid_o SHALL be 0 in any cycle following a cycle with no accepted search.
REQ-023 Result outputs SHALL hold their previous values while result_valid_o=0.
REQ-024 match_addr_o SHALL be the lowest index with match_vector_o bit set, and 0 when match_o=0.
REQ-025 A write and a search in the same cycle, including to the same entry, SHALL search the pre-write contents.
REQ-026 An all-zero search_mask_i SHALL match every valid entry.
REQ-027 The FSM SHALL have states IDLE and FLUSH.
REQ-028 In IDLE, flush_i=1 SHALL enter FLUSH with flush pointer 0; busy_o SHALL assert in the next cycle.
REQ-029 In FLUSH, each cycle SHALL clear valid[ptr] and increment ptr; after clearing entry DEPTH-1 the FSM SHALL return to IDLE, so busy_o is high for exactly DEPTH cycles.
REQ-030 In FLUSH, writes and searches SHALL be ignored (dropped, not queued), and flush_i SHALL be ignored.
REQ-031 A write or search in the same cycle flush_i is accepted in IDLE SHALL still execute.
REQ-032 A flush SHALL change valid bits only; data contents SHALL be retained.

Reset
REQ-033 reset SHALL take priority over all other inputs in the cycle it is sampled.
REQ-034 reset SHALL clear every valid bit and every data word to 0.
REQ-035 reset SHALL force the FSM to IDLE and the flush pointer to 0.
REQ-036 After reset, result_valid_o, match_o, match_addr_o, match_vector_o and busy_o SHALL all be 0.
REQ-037 reset asserted during FLUSH SHALL abort the flush immediately.

Structure
REQ-038 Package cam_pkg SHALL hold the FSM state enum (IDLE, FLUSH) and the default WIDTH/DEPTH constants.
REQ-039 Sub-module cam_entry SHALL hold one WIDTH-bit word plus its valid bit, with write, clear and masked-compare logic, instantiated DEPTH times.
REQ-040 The priority encoder and result registers SHALL reside in cam_array.

Verification
REQ-041 Write 0x5A@3, 0x5A@9, then search 0x5A with mask 0xFF -> next cycle match_o=1, match_addr_o=3, match_vector_o=0x0208.
REQ-042 Write 0xA5@4, then search 0xA0 with mask 0xF0 -> match_addr_o=4; search 0xA0 with mask 0xFF -> match_o=0, match_addr_o=0.
REQ-043 Write 0x11@2, then in the same cycle write 0x22@2 and search 0x11 -> match_o=1, match_addr_o=2; searching 0x11 again -> match_o=0.
REQ-044 Fill all 16 entries, pulse flush_i -> busy_o high 16 cycles; a write during FLUSH is dropped; afterwards any search gives match_vector_o=0.
REQ-045 Assert reset in the 5th FLUSH cycle -> busy_o=0 next cycle, all outputs 0, all entries invalid.
REQ-046 Write 0x3C@7 with write_valid_i=0, then search 0x3C with mask 0xFF -> match_o=0.
